// File: rtl/phase_a_loader_pkg.sv
// Shared definitions for the phase_a operand loader.
//   SIZE     : operand / modulus width in bits
//   RADIX    : phase_a digit width; m_prime carries RADIX+2 bits
//   W        : stream word width (must divide SIZE)
//   WORDS    : stream words per a or m
//   MP_WORDS : stream words carrying m_prime
//   state_e  : loader FSM encoding
//   neg_top_bits() : top two bits of the negated modulus from the final borrow carry
package phase_a_loader_pkg;

  localparam int SIZE      = 3072;
  localparam int RADIX     = 108;
  localparam int W         = 64;
  localparam int WORDS     = SIZE / W;
  localparam int MP_BITS   = RADIX + 2;
  localparam int MP_WORDS  = (MP_BITS + W - 1) / W;
  // Words of m_prime that must be held until the final word arrives.
  localparam int MP_HOLD_W = (MP_WORDS - 1) * W;
  localparam int CNT_W     = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_M  = 3'd1,
    LOAD_MP = 3'd2,
    LOAD_A  = 3'd3,
    FIRE    = 3'd4,
    WAIT    = 3'd5
  } state_e;

  // Carry out of the whole ~m+1 chain is 1 only when m == 0, in which case
  // the negation is zero in every bit; otherwise the extension bits are 11.
  function automatic logic [1:0] neg_top_bits(input logic final_carry);
    return 2'b11 + {1'b0, final_carry};
  endfunction

endpackage

// File: rtl/phase_a_loader_if.sv
// Bundle of the loader's command, stream, operand and phase_a handshake signals.
//   master : the side issuing commands, streaming words and reporting done_in
//   slave  : the loader itself
//   cmd_valid/cmd_ready/cmd_load_m : operation request handshake
//   s_valid/s_ready/s_data         : word-serial stream, least-significant word first
//   a/m/m_n/m_prime                : assembled operands towards phase_a
//   en/done_in/busy                : phase_a start pulse, completion pulse, activity flag
interface phase_a_loader_if;
  import phase_a_loader_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_load_m;
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_data;
  logic [SIZE-1:0]     a;
  logic [SIZE-1:0]     m;
  logic [SIZE+1:0]     m_n;
  logic [MP_BITS-1:0]  m_prime;
  logic                en;
  logic                done_in;
  logic                busy;

  modport master (
    output cmd_valid, cmd_load_m, s_valid, s_data, done_in,
    input  cmd_ready, s_ready, a, m, m_n, m_prime, en, busy
  );

  modport slave (
    input  cmd_valid, cmd_load_m, s_valid, s_data, done_in,
    output cmd_ready, s_ready, a, m, m_n, m_prime, en, busy
  );

endinterface

// File: rtl/phase_a_loader_word_negate.sv
// word_negate unit: one limb of a limb-serial two's-complement negation.
// Computes y = ~x + cin over WIDTH bits and reports the carry out, so that
// chaining limbs (carry seeded with 1) yields -X for a multi-limb value X.
//   x_i    : input limb
//   cin_i  : carry from the previous (less significant) limb
//   y_o    : negated limb
//   cout_o : carry into the next limb
module phase_a_loader_word_negate #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o
);

  assign {cout_o, y_o} = {1'b0, ~x_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/phase_a_loader.sv
// Upstream operand stage for phase_a.
// Assembles modulus m, Montgomery constant m_prime and operand a from a
// word-serial stream, builds the negated modulus m_n on the fly while m
// streams in, fires phase_a with a one-cycle en pulse and then holds every
// operand stable until phase_a reports completion on done_in. m / m_prime
// stay valid across operations so later commands may skip reloading them.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : phase_a_loader_if slave modport (command, stream, operands, handshakes)
module phase_a_loader
  import phase_a_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  phase_a_loader_if.slave  bus
);

  localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] MP_LAST = CNT_W'(MP_WORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                m_loaded_q, m_loaded_d;
  logic [SIZE-1:0]     a_q, a_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [SIZE+1:0]     m_n_q, m_n_d;
  logic [MP_HOLD_W-1:0] mp_q, mp_d;
  logic [MP_BITS-1:0]  m_prime_q, m_prime_d;
  logic                en_q, en_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;

  logic                xfer_s;
  logic [W-1:0]        neg_word_s;
  logic                neg_cout_s;

  // s_ready is registered, so a transfer is simply valid meeting that flag.
  assign xfer_s = bus.s_valid & s_ready_q;

  phase_a_loader_word_negate #(
    .WIDTH (W)
  ) u_word_negate (
    .x_i    (bus.s_data),
    .cin_i  (carry_q),
    .y_o    (neg_word_s),
    .cout_o (neg_cout_s)
  );

  // Next-state and datapath update for the loader FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    m_loaded_d = m_loaded_q;
    a_d        = a_q;
    m_d        = m_q;
    m_n_d      = m_n_q;
    mp_d       = mp_q;
    m_prime_d  = m_prime_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cnt_d = '0;
          if (bus.cmd_load_m || !m_loaded_q) begin
            state_d = LOAD_M;
            // Seeds the +1 of the two's-complement negation.
            carry_d = 1'b1;
          end else begin
            state_d = LOAD_A;
          end
        end else begin
          state_d = IDLE;
        end
      end

      LOAD_M: begin
        if (xfer_s) begin
          m_d              = {bus.s_data, m_q[SIZE-1:W]};
          m_n_d[SIZE-1:0]  = {neg_word_s, m_n_q[SIZE-1:W]};
          carry_d          = neg_cout_s;
          if (cnt_q == A_LAST) begin
            m_n_d[SIZE+1:SIZE] = neg_top_bits(neg_cout_s);
            cnt_d              = '0;
            state_d            = LOAD_MP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = LOAD_M;
        end
      end

      LOAD_MP: begin
        if (xfer_s) begin
          // Only the earlier words are held; the last one is taken straight
          // from the stream and bits above MP_BITS are dropped.
          mp_d = MP_HOLD_W'({bus.s_data, mp_q} >> W);
          if (cnt_q == MP_LAST) begin
            m_prime_d  = MP_BITS'({bus.s_data, mp_q});
            m_loaded_d = 1'b1;
            cnt_d      = '0;
            state_d    = LOAD_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = LOAD_MP;
        end
      end

      LOAD_A: begin
        if (xfer_s) begin
          a_d = {bus.s_data, a_q[SIZE-1:W]};
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = FIRE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = LOAD_A;
        end
      end

      FIRE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.done_in) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status flags decoded from the next state so they are registered.
  always_comb begin
    en_d        = 1'b0;
    cmd_ready_d = 1'b0;
    s_ready_d   = 1'b0;
    busy_d      = 1'b1;
    case (state_d)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      LOAD_M, LOAD_MP, LOAD_A: begin
        s_ready_d = 1'b1;
      end
      FIRE: begin
        en_d = 1'b1;
      end
      WAIT: begin
        en_d = 1'b0;
      end
      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      m_loaded_q  <= 1'b0;
      a_q         <= '0;
      m_q         <= '0;
      m_n_q       <= '0;
      mp_q        <= '0;
      m_prime_q   <= '0;
      en_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      m_loaded_q  <= m_loaded_d;
      a_q         <= a_d;
      m_q         <= m_d;
      m_n_q       <= m_n_d;
      mp_q        <= mp_d;
      m_prime_q   <= m_prime_d;
      en_q        <= en_d;
      cmd_ready_q <= cmd_ready_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.a         = a_q;
  assign bus.m         = m_q;
  assign bus.m_n       = m_n_q;
  assign bus.m_prime   = m_prime_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_phase_a_loader.sv
// Directed self-checking bench for phase_a_loader.
module tb_phase_a_loader;
  import phase_a_loader_pkg::*;

  localparam logic [MP_BITS-1:0] MP_EXP1 = {46'h3FFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_a_loader_if bus ();

  phase_a_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xfers    = 0;
  int en_cnt   = 0;
  int en_cyc   = 0;
  int acc_cyc  = 0;

  logic [W-1:0]    m_words [WORDS];
  logic [W-1:0]    mp_words[MP_WORDS];
  logic [W-1:0]    a_words [WORDS];
  logic [SIZE-1:0] m_exp;
  logic [SIZE-1:0] a_exp;

  // Passive monitor: cycle count, stream transfers and en pulses (pre-edge values).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.s_valid && bus.s_ready) xfers = xfers + 1;
    if (bus.en) begin
      en_cnt = en_cnt + 1;
      en_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_exp();
    for (int i = 0; i < WORDS; i++) begin
      m_exp[i*W +: W] = m_words[i];
      a_exp[i*W +: W] = a_words[i];
    end
  endtask

  task automatic set_scn1_data();
    for (int i = 0; i < WORDS; i++) begin
      m_words[i] = 64'd0;
      a_words[i] = 64'(i + 1);
    end
    m_words[0]  = 64'd1;
    mp_words[0] = 64'h0123_4567_89AB_CDEF;
    mp_words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    build_exp();
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic issue_cmd(input logic load_m);
    int t;
    t = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_load_m = load_m;
    while (bus.cmd_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] d, input int gap);
    int t;
    if (gap > 0) begin
      bus.s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    t = 0;
    while (bus.s_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: s_ready=%b required 1", bus.s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic load_m, input logic push_m, input logic rand_gap, input int done_at);
    issue_cmd(load_m);
    if (push_m) begin
      for (int i = 0; i < WORDS; i++) push_word(m_words[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
      for (int i = 0; i < MP_WORDS; i++) push_word(mp_words[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
    end
    for (int i = 0; i < WORDS; i++) begin
      if (i == done_at) begin
        bus.s_valid = 1'b0;
        bus.done_in = 1'b1;
        @(posedge clk); #1;
        bus.done_in = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL done_in_in_load_a: busy=%b s_ready=%b required 1 1", bus.busy, bus.s_ready);
        end
      end
      push_word(a_words[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic finish_op();
    bus.done_in = 1'b1;
    @(posedge clk); #1;
    bus.done_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.a !== '0 || bus.m !== '0 || bus.m_n !== '0 || bus.m_prime !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: a/m/m_n/m_prime not all zero (m_prime=%h)", bus.m_prime);
    end
    n_checks++;
    if (bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: en=%b busy=%b cmd_ready=%b s_ready=%b required 0 0 1 0",
               bus.en, bus.busy, bus.cmd_ready, bus.s_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    int x0, e0;
    set_scn1_data();
    x0 = xfers; e0 = en_cnt;
    run_op(1'b1, 1'b1, 1'b0, -1);
    n_checks++;
    if (bus.en !== 1'b1) begin
      n_fail++; $display("FAIL en_after_last_xfer: en=%b required 1", bus.en);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.en !== 1'b0 || bus.busy !== 1'b1 || bus.s_ready !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_flags: en=%b busy=%b s_ready=%b cmd_ready=%b required 0 1 0 0",
               bus.en, bus.busy, bus.s_ready, bus.cmd_ready);
    end
    n_checks++;
    if (en_cyc - acc_cyc != 99) begin
      n_fail++; $display("FAIL latency_full: got %0d cycles required 99", en_cyc - acc_cyc);
    end
    n_checks++;
    if (xfers - x0 != 98 || en_cnt - e0 != 1) begin
      n_fail++; $display("FAIL counts_full: xfers=%0d en=%0d required 98 1", xfers - x0, en_cnt - e0);
    end
    n_checks++;
    if (bus.m !== m_exp || bus.a !== a_exp) begin
      n_fail++; $display("FAIL m_a_full: m_low=%h a_top=%h required 1 and 48", bus.m[63:0], bus.a[SIZE-1 -: W]);
    end
    n_checks++;
    if (bus.m_n !== {(SIZE+2){1'b1}}) begin
      n_fail++; $display("FAIL m_n_of_one: top=%b low=%h required all ones", bus.m_n[SIZE+1:SIZE], bus.m_n[63:0]);
    end
    n_checks++;
    if (bus.m_prime !== MP_EXP1) begin
      n_fail++; $display("FAIL m_prime: got %h required %h", bus.m_prime, MP_EXP1);
    end
    repeat (3) @(posedge clk);
    #1;
    finish_op();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_to_idle: busy=%b cmd_ready=%b required 0 1", bus.busy, bus.cmd_ready);
    end
  endtask

  task automatic test_reuse_m();
    int x0, e0;
    for (int i = 0; i < WORDS; i++) a_words[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    build_exp();
    x0 = xfers; e0 = en_cnt;
    run_op(1'b0, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    n_checks++;
    if (xfers - x0 != 48 || en_cnt - e0 != 1 || en_cyc - acc_cyc != 49) begin
      n_fail++;
      $display("FAIL reuse_counts: xfers=%0d en=%0d latency=%0d required 48 1 49",
               xfers - x0, en_cnt - e0, en_cyc - acc_cyc);
    end
    n_checks++;
    if (bus.m !== m_exp || bus.m_n !== {(SIZE+2){1'b1}} || bus.m_prime !== MP_EXP1) begin
      n_fail++; $display("FAIL reuse_m_held: m_low=%h m_prime=%h required 1 %h", bus.m[63:0], bus.m_prime, MP_EXP1);
    end
    n_checks++;
    if (bus.a !== a_exp) begin
      n_fail++; $display("FAIL reuse_a: a_low=%h required a5a5000000000000", bus.a[63:0]);
    end
    finish_op();
  endtask

  task automatic test_m_special();
    for (int i = 0; i < WORDS; i++) m_words[i] = 64'd0;
    build_exp();
    run_op(1'b1, 1'b1, 1'b0, -1);
    @(posedge clk); #1;
    n_checks++;
    if (bus.m_n !== '0) begin
      n_fail++; $display("FAIL m_n_of_zero: top=%b low=%h required 00 0", bus.m_n[SIZE+1:SIZE], bus.m_n[63:0]);
    end
    finish_op();
    m_words[WORDS-1] = 64'h8000_0000_0000_0000;
    build_exp();
    run_op(1'b1, 1'b1, 1'b0, -1);
    @(posedge clk); #1;
    n_checks++;
    if (bus.m_n[SIZE+1:SIZE] !== 2'b11 || bus.m_n[SIZE-1:0] !== {1'b1, {(SIZE-1){1'b0}}}) begin
      n_fail++;
      $display("FAIL m_n_of_msb: top=%b word47=%h low=%h required 11 8000000000000000 0",
               bus.m_n[SIZE+1:SIZE], bus.m_n[SIZE-1 -: W], bus.m_n[63:0]);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    int x0, e0;
    set_scn1_data();
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL s_ready_idle: got %b required 0", bus.s_ready);
    end
    x0 = xfers; e0 = en_cnt;
    run_op(1'b1, 1'b1, 1'b1, -1);
    n_checks++;
    if (bus.en !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_fire: en=%b s_ready=%b required 1 0", bus.en, bus.s_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.s_ready !== 1'b0 || xfers - x0 != 98 || en_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL bp_counts: s_ready=%b xfers=%0d en=%0d required 0 98 1", bus.s_ready, xfers - x0, en_cnt - e0);
    end
    n_checks++;
    if (bus.m !== m_exp || bus.a !== a_exp || bus.m_n !== {(SIZE+2){1'b1}} || bus.m_prime !== MP_EXP1) begin
      n_fail++; $display("FAIL bp_data: m_low=%h a_low=%h m_prime=%h", bus.m[63:0], bus.a[63:0], bus.m_prime);
    end
    finish_op();
  endtask

  task automatic test_mid_reset();
    int x0;
    issue_cmd(1'b0);
    for (int i = 0; i < 10; i++) push_word(64'hDEAD_0000_0000_0000 | 64'(i), 0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (bus.a !== '0 || bus.m !== '0 || bus.m_n !== '0 || bus.m_prime !== '0 || bus.en !== 1'b0) begin
      n_fail++; $display("FAIL midreset_operands: a_low=%h m_low=%h m_prime=%h required 0", bus.a[63:0], bus.m[63:0], bus.m_prime);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: busy=%b cmd_ready=%b s_ready=%b required 0 1 0", bus.busy, bus.cmd_ready, bus.s_ready);
    end
    set_scn1_data();
    x0 = xfers;
    run_op(1'b0, 1'b1, 1'b0, -1);
    @(posedge clk); #1;
    n_checks++;
    if (xfers - x0 != 98 || bus.m !== m_exp || bus.m_prime !== MP_EXP1) begin
      n_fail++; $display("FAIL midreset_forces_load_m: xfers=%0d m_low=%h required 98 1", xfers - x0, bus.m[63:0]);
    end
    finish_op();
  endtask

  task automatic test_ignore();
    int x0, e0;
    for (int i = 0; i < WORDS; i++) a_words[i] = 64'h0F0F_0F0F_0000_0000 | 64'(i * 3);
    build_exp();
    e0 = en_cnt;
    run_op(1'b0, 1'b0, 1'b0, 20);
    @(posedge clk); #1;
    n_checks++;
    if (en_cnt - e0 != 1 || bus.a !== a_exp) begin
      n_fail++; $display("FAIL ignore_done_load_a: en=%0d a_low=%h required 1 0f0f0f0f00000000", en_cnt - e0, bus.a[63:0]);
    end
    x0 = xfers;
    bus.cmd_valid  = 1'b1;
    bus.cmd_load_m = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL cmd_in_wait: cmd_ready=%b busy=%b s_ready=%b required 0 1 0", bus.cmd_ready, bus.busy, bus.s_ready);
    end
    bus.cmd_valid = 1'b0;
    finish_op();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || xfers != x0 || bus.a !== a_exp) begin
      n_fail++; $display("FAIL done_after_wait: busy=%b cmd_ready=%b xfers=%0d required 0 1 0", bus.busy, bus.cmd_ready, xfers - x0);
    end
    finish_op();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.en !== 1'b0) begin
      n_fail++; $display("FAIL done_in_idle: busy=%b cmd_ready=%b en=%b required 0 1 0", bus.busy, bus.cmd_ready, bus.en);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_load_m = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = 64'd0;
    bus.done_in    = 1'b0;
    test_reset();
    test_full_load();
    test_reuse_m();
    test_m_special();
    test_backpressure();
    test_mid_reset();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_a_loader.md
Name: phase_a_loader

Overview:
Upstream operand stage for phase_a.
- Accepts a word-serial stream carrying modulus m, Montgomery constant m_prime and operand a, assembling each into a full-width register.
- Computes the negated modulus m_n on the fly while m streams in.
- Fires phase_a with a single-cycle en pulse, then holds all operands stable until phase_a reports completion; m and m_prime can be retained across operations.

Parameters:
Size, 3072, operand/modulus width in bits
radix, 108, digit width; m_prime is radix+2 bits
W, 64, stream word width; W must divide Size
WORDS, Size/W (=48), words per a or m
MP_WORDS, ceil((radix+2)/W) (=2), words for m_prime

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid  in  1  start-operation request
cmd_ready  out  1  high only in IDLE
cmd_load_m  in  1  1 = stream m and m_prime before a; 0 = reuse stored m/m_prime
s_valid  in  1  stream word valid
s_ready  out  1  high only in LOAD_M, LOAD_MP, LOAD_A
s_data  in  W  stream word, least-significant word first
a  out  Size  assembled operand to phase_a
m  out  Size  assembled modulus
m_n  out  Size+2  (2^(Size+2) - m) mod 2^(Size+2)
m_prime  out  radix+2  low radix+2 bits of the m_prime words
en  out  1  one-cycle start pulse to phase_a
done_in  in  1  phase_a en_out pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; a, m, m_n, m_prime, en, busy, m_loaded, word counter, borrow carry all 0.
- A cycle with rst high overrides everything, including mid-load or mid-WAIT: partially loaded data is discarded and m_loaded is cleared.
- IDLE: cmd_ready=1. On cmd_valid:
  - to LOAD_M if cmd_load_m=1 or m_loaded=0;
  - otherwise to LOAD_A.
  - Counter cleared. For LOAD_M, carry is set to 1.
- Word transfer occurs only when s_valid&s_ready. Counter increments once per transfer. No transfer means no state change (arbitrary backpressure allowed).
- LOAD_M, per word:
  - m <= {s_data, m[Size-1:W]};
  - negation word nw = ~s_data + carry (W-bit sum); carry <= carry-out;
  - m_n[Size-1:0] shifts right with nw inserted at the top.
  - On the WORDS-th transfer: m_n[Size+1:Size] <= 2'b11 + carry (m=0 gives 00, otherwise 11); go to LOAD_MP.
- LOAD_MP:
  - mp shift register (MP_WORDS*W bits) shifts right, inserting s_data at the top.
  - On the last transfer: m_prime <= low radix+2 bits of the final register value; upper bits are discarded; m_loaded <= 1; go to LOAD_A.
- LOAD_A: a shifts right, inserting s_data at the top. On the WORDS-th transfer, go to FIRE.
- FIRE: lasts exactly 1 cycle; en=1 (registered, so it rises the cycle after the last a handshake); go to WAIT.
- WAIT: en=0. a, m, m_n and m_prime are frozen. On done_in=1, go to IDLE.
- done_in outside WAIT is ignored.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Outputs a, m, m_n, m_prime change only during their LOAD state and are otherwise held.
- Throughput: with no backpressure, from cmd accept to en there are WORDS(+WORDS+MP_WORDS) transfer cycles plus 1.

Decomposition:
- Shared package: WORDS, MP_WORDS, the state encoding (IDLE, LOAD_M, LOAD_MP, LOAD_A, FIRE, WAIT).
- One sub-module, word_negate: combinational W-bit ~x+cin with carry out. It is reused by any later limb-serial subtractor.

Test Plan:
1. cmd_load_m=1; m = 1 (word0 = 1, rest 0); m_prime words {0x0123..., 0xFFFF...}; a = words 1..48, no backpressure.
   - m_n = all ones (3074 bits);
   - m_prime = low 110 bits of the two words;
   - en pulses exactly 1 cycle, 1 cycle after the 98th transfer.
2. m = 0: m_n = 0, top bits 00.
   - m = 2^3071 (only bit 3071 set): m_n[3073:3072] = 11 and m_n[3071:0] = 2^3071.
3. s_valid toggling 1,0,0,1 with random gaps during all loads: same results as scenario 1; word count exact; s_ready low in FIRE/WAIT/IDLE.
4. After scenario 1 plus done_in, issue cmd_load_m=0 with a new a: goes directly to LOAD_A; only 48 words consumed; m/m_n/m_prime unchanged; en pulses once.
5. rst=1 after 10 words of LOAD_A: all outputs 0, state IDLE. Then cmd_load_m=0 still forces LOAD_M because m_loaded=0.
6. done_in pulse during LOAD_A: ignored.
   - In WAIT, a cmd_valid: not accepted.
   - done_in: busy drops the next cycle, cmd_ready=1.
